// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the packet-aware stream demultiplexer.
package stream_demux_pkg;

  // IDLE: next accepted beat starts a packet; LOCKED: mid-packet, route held.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } demux_state_t;

  // Width of the saturating dropped-packet counter.
  localparam int DROP_W = 8;

endpackage : stream_demux_pkg

// File: rtl/demux_slot.sv
// One-entry register slot: accepts a beat whenever it is empty or draining,
// so a steady stream passes at one beat per cycle with one cycle of latency.
module demux_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last
);

  logic full;

  // Room exists if the slot is empty or its current beat leaves this cycle.
  assign in_ready  = !full || out_ready;
  assign out_valid = full;

  // Fill takes priority over drain so a simultaneous drain/fill stays full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: payload registers are reset too, because the outputs must read
      // zero after reset rather than whatever the flops powered up with.
      full     <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if (in_valid && in_ready) begin
      // NOTE: non-blocking assignments in clocked blocks keep every flop
      // sampling pre-edge values regardless of statement order.
      full     <= 1'b1;
      out_data <= in_data;
      out_last <= in_last;
    end else if (out_ready) begin
      full     <= 1'b0;
    end
  end

endmodule : demux_slot

// File: rtl/stream_demux.sv
// Packet-aware 1-to-N stream demultiplexer. The destination is taken from
// up_sel on a packet's first beat and held until its last beat; beats aimed
// at a non-existent channel are swallowed and counted per packet.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [W-1:0]      up_data,
  input  logic              up_last,
  input  logic [SW-1:0]     up_sel,
  output logic [N-1:0]      down_valid,
  input  logic [N-1:0]      down_ready,
  output logic [N*W-1:0]    down_data,
  output logic [N-1:0]      down_last,
  output logic [DROP_W-1:0] drop_count
);

  demux_state_t      state;
  logic [SW-1:0]     cur_ch;
  logic [SW-1:0]     route;
  logic              route_ok;
  logic              accept;
  logic [N-1:0]      slot_ready;
  logic [N-1:0]      slot_wr;
  logic [DROP_W-1:0] drops;

  // First beat follows up_sel live; later beats follow the latched channel.
  assign route  = (state == LOCKED) ? cur_ch : up_sel;
  assign accept = up_valid && up_ready;

  // Decode the route: pick the target slot's ready and write strobe, or
  // accept-and-discard when the route names no existing channel.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a value held and no latch is inferred.
    route_ok = 1'b0;
    up_ready = 1'b1;
    slot_wr  = '0;
    for (int i = 0; i < N; i++) begin
      if (route == SW'(i)) begin
        route_ok   = 1'b1;
        up_ready   = slot_ready[i];
        slot_wr[i] = up_valid && slot_ready[i];
      end
    end
  end

  // Packet framing: lock the channel on a non-final first beat, unlock on last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cur_ch <= '0;
    end else if (accept) begin
      if (state == IDLE && !up_last) begin
        state  <= LOCKED;
        cur_ch <= up_sel;
      end else if (state == LOCKED && up_last) begin
        state  <= IDLE;
      end
    end
  end

  // Count whole discarded packets, once each on their final beat, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drops <= '0;
    end else if (accept && up_last && !route_ok && drops != '1) begin
      drops <= drops + 1'b1;
    end
  end

  assign drop_count = drops;

  // One register slot per output channel; channel i owns data bits [i*W +: W].
  for (genvar i = 0; i < N; i++) begin : g_slot
    demux_slot #(.W(W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (slot_wr[i]),
      .in_data   (up_data),
      .in_last   (up_last),
      .in_ready  (slot_ready[i]),
      .out_valid (down_valid[i]),
      .out_ready (down_ready[i]),
      .out_data  (down_data[i*W +: W]),
      .out_last  (down_last[i])
    );
  end

endmodule : stream_demux

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a 4-channel and a 3-channel instance share clock
// and reset. A packet-level model (per-channel FIFOs of expected beats plus a
// saturating drop tally) is compared with both DUTs on every falling edge.
module tb_stream_demux;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Stimulus, index 0 = 4-channel DUT, index 1 = 3-channel DUT.
  logic       up_valid [2];
  logic [7:0] up_data  [2];
  logic       up_last  [2];
  logic [1:0] up_sel   [2];
  logic [3:0] dr       [2];

  // Raw DUT outputs.
  logic        ur0, ur1;
  logic [3:0]  dv0, dl0;
  logic [31:0] dd0;
  logic [2:0]  dv1, dl1;
  logic [23:0] dd1;
  logic [7:0]  dc0, dc1;

  // Outputs gathered into arrays for uniform checking.
  logic        ur [2];
  logic [3:0]  dv [2];
  logic [3:0]  dl [2];
  logic [31:0] dd [2];
  logic [7:0]  dc [2];

  always_comb begin
    ur[0] = ur0;  ur[1] = ur1;
    dv[0] = dv0;  dv[1] = {1'b0, dv1};
    dl[0] = dl0;  dl[1] = {1'b0, dl1};
    dd[0] = dd0;  dd[1] = {8'h00, dd1};
    dc[0] = dc0;  dc[1] = dc1;
  end

  stream_demux #(.N(4), .W(8)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid[0]),
    .up_ready   (ur0),
    .up_data    (up_data[0]),
    .up_last    (up_last[0]),
    .up_sel     (up_sel[0]),
    .down_valid (dv0),
    .down_ready (dr[0]),
    .down_data  (dd0),
    .down_last  (dl0),
    .drop_count (dc0)
  );

  stream_demux #(.N(3), .W(8)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid[1]),
    .up_ready   (ur1),
    .up_data    (up_data[1]),
    .up_last    (up_last[1]),
    .up_sel     (up_sel[1]),
    .down_valid (dv1),
    .down_ready (dr[1][2:0]),
    .down_data  (dd1),
    .down_last  (dl1),
    .drop_count (dc1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- packet-level model ----------------
  beat_t q [2][4][$];
  logic  in_pkt [2];
  int    pkt_ch [2];
  int    drops  [2];
  int    nch    [2];

  initial begin
    nch[0] = 4;
    nch[1] = 3;
    for (int k = 0; k < 2; k++) begin
      in_pkt[k] = 1'b0;
      pkt_ch[k] = 0;
      drops[k]  = 0;
    end
  end

  // Compare outputs with the model, then advance the model for the next edge.
  always @(negedge clk) begin : compare
    int   r;
    logic exp_ur;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        for (int c = 0; c < 4; c++) q[k][c].delete();
        in_pkt[k] = 1'b0;
        drops[k]  = 0;
        check($sformatf("rst_up_ready[%0d]", k), 32'(ur[k]), 32'd1);
        check($sformatf("rst_valid[%0d]", k), 32'(dv[k]), 32'd0);
        check($sformatf("rst_data[%0d]", k), dd[k], 32'd0);
        check($sformatf("rst_last[%0d]", k), 32'(dl[k]), 32'd0);
        check($sformatf("rst_drops[%0d]", k), 32'(dc[k]), 32'd0);
      end else begin
        r = in_pkt[k] ? pkt_ch[k] : int'(up_sel[k]);
        exp_ur = (r >= nch[k]) ? 1'b1 : (q[k][r].size() == 0 || dr[k][r]);
        check($sformatf("up_ready[%0d]", k), 32'(ur[k]), 32'(exp_ur));
        for (int c = 0; c < nch[k]; c++) begin
          check($sformatf("valid[%0d][%0d]", k, c), 32'(dv[k][c]), 32'(q[k][c].size() != 0));
          if (q[k][c].size() != 0) begin
            check($sformatf("data[%0d][%0d]", k, c), 32'(dd[k][c*8 +: 8]), 32'(q[k][c][0].data));
            check($sformatf("last[%0d][%0d]", k, c), 32'(dl[k][c]), 32'(q[k][c][0].last));
          end
        end
        check($sformatf("drops[%0d]", k), 32'(dc[k]), 32'(drops[k]));
        // Effects of the coming rising edge: drains first, then the new beat.
        for (int c = 0; c < nch[k]; c++)
          if (q[k][c].size() != 0 && dr[k][c]) void'(q[k][c].pop_front());
        if (up_valid[k] && exp_ur) begin
          if (r < nch[k]) q[k][r].push_back('{data: up_data[k], last: up_last[k]});
          if (up_last[k]) begin
            if (r >= nch[k] && drops[k] < 255) drops[k]++;
            in_pkt[k] = 1'b0;
          end else if (!in_pkt[k]) begin
            in_pkt[k] = 1'b1;
            pkt_ch[k] = r;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Present one beat and hold it until accepted; returns cycles taken.
  task automatic send(input int k, input logic [7:0] d, input logic [1:0] s,
                      input logic l, output int cycles);
    logic acc;
    cycles = 0;
    up_valid[k] = 1'b1;
    up_data[k]  = d;
    up_sel[k]   = s;
    up_last[k]  = l;
    do begin
      @(negedge clk);
      acc = ur[k];
      @(posedge clk);
      #1;
      cycles++;
    end while (!acc && cycles < 50);
    check($sformatf("send_accepted[%0d]", k), 32'(acc), 32'd1);
    up_valid[k] = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cyc;
    for (int k = 0; k < 2; k++) begin
      up_valid[k] = 1'b0;
      up_data[k]  = '0;
      up_last[k]  = 1'b0;
      up_sel[k]   = '0;
      dr[k]       = 4'b1111;
    end
    tick(3);
    rst = 1'b1;
    tick(2);

    // Single-beat routing to channel 2.
    send(0, 8'hA5, 2'd2, 1'b1, cyc);
    check("single_valid", 32'(dv[0]), 32'h4);
    check("single_data", 32'(dd[0][23:16]), 32'hA5);
    check("single_last", 32'(dl[0][2]), 32'd1);
    tick(2);

    // Select lock: up_sel moves to 3 after the first beat, beats stay on 1.
    send(0, 8'h11, 2'd1, 1'b0, cyc);
    check("lock_b1_valid", 32'(dv[0]), 32'h2);
    send(0, 8'h22, 2'd3, 1'b0, cyc);
    check("lock_b2_data", 32'(dd[0][15:8]), 32'h22);
    send(0, 8'h33, 2'd3, 1'b1, cyc);
    check("lock_b3_valid", 32'(dv[0]), 32'h2);
    check("lock_b3_data", 32'(dd[0][15:8]), 32'h33);
    check("lock_b3_last", 32'(dl[0][1]), 32'd1);
    tick(2);

    // Backpressure on channel 0, with channel 3 streaming alongside.
    dr[0] = 4'b1110;
    send(0, 8'h40, 2'd0, 1'b1, cyc);
    for (int i = 0; i < 3; i++) begin
      send(0, 8'h70 + 8'(i), 2'd3, 1'b1, cyc);
      check("indep_full_rate", 32'(cyc), 32'd1);
      check("indep_ch3_data", 32'(dd[0][31:24]), 32'(8'h70 + 8'(i)));
    end
    up_valid[0] = 1'b1;
    up_data[0]  = 8'h41;
    up_sel[0]   = 2'd0;
    up_last[0]  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_stall_ready", 32'(ur[0]), 32'd0);
      check("bp_held_data", 32'(dd[0][7:0]), 32'h40);
    end
    @(posedge clk);
    #1;
    dr[0] = 4'b1111;
    @(negedge clk);
    check("bp_release_ready", 32'(ur[0]), 32'd1);
    @(posedge clk);
    #1;
    up_valid[0] = 1'b0;
    check("bp_no_bubble_valid", 32'(dv[0][0]), 32'd1);
    check("bp_no_bubble_data", 32'(dd[0][7:0]), 32'h41);
    tick(2);

    // Drop path on the 3-channel instance.
    send(1, 8'hD0, 2'd3, 1'b0, cyc);
    send(1, 8'hD1, 2'd3, 1'b1, cyc);
    check("drop_no_valid", 32'(dv[1]), 32'd0);
    check("drop_count_one", 32'(dc[1]), 32'd1);
    for (int p = 0; p < 300; p++) begin
      send(1, 8'(p), 2'd3, 1'b0, cyc);
      send(1, 8'(p), 2'd3, 1'b1, cyc);
    end
    check("drop_saturated", 32'(dc[1]), 32'd255);
    tick(2);

    // Reset in the middle of a 4-beat packet to channel 1.
    send(0, 8'h51, 2'd1, 1'b0, cyc);
    send(0, 8'h52, 2'd1, 1'b0, cyc);
    rst = 1'b0;
    #1;
    check("midrst_valid", 32'(dv[0]), 32'd0);
    check("midrst_data", dd[0], 32'd0);
    tick(2);
    rst = 1'b1;
    tick(1);
    send(0, 8'h99, 2'd0, 1'b1, cyc);
    check("post_rst_valid", 32'(dv[0]), 32'h1);
    check("post_rst_data", 32'(dd[0][7:0]), 32'h99);
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_stream_demux
